// File: rtl/lif_spike_monitor.sv
// Windowed spike statistics for a LIF neuron: spike count, last inter-spike interval
// and peak membrane state, published once per window through a one-entry output register.
module lif_spike_monitor #(
  parameter int WINDOW_LEN = 256,
  parameter int COUNT_W    = 8,
  parameter int ISI_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike,
  input  logic [7:0]         state,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COUNT_W-1:0] spike_count,
  output logic [ISI_W-1:0]   isi,
  output logic [7:0]         peak_state,
  output logic               overrun
);

  localparam int WCNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(WINDOW_LEN - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [ISI_W-1:0]   ISI_MAX   = '1;

  logic [WCNT_W-1:0]  wcnt;
  logic [COUNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]         pk, pk_nxt;
  logic [ISI_W-1:0]   gap, gap_inc, last_isi, last_isi_nxt;
  logic               seen;
  logic               win_end, xfer, load;

  // Handshake: a record transfers on any edge where out_valid and out_ready are both high;
  // the record registers stay stable until then, and a window end that finds the register
  // occupied and not being drained is dropped and flagged in overrun.
  always_comb begin
    gap_inc      = (gap == ISI_MAX) ? gap : gap + 1'b1;
    cnt_nxt      = (spike && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
    pk_nxt       = (state > pk) ? state : pk;
    last_isi_nxt = (spike && seen) ? gap_inc : last_isi;
    win_end      = enable && (wcnt == WCNT_LAST);
    xfer         = out_valid && out_ready;
    load         = win_end && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt        <= '0;
      cnt         <= '0;
      pk          <= '0;
      gap         <= '0;
      last_isi    <= '0;
      seen        <= 1'b0;
      out_valid   <= 1'b0;
      spike_count <= '0;
      isi         <= '0;
      peak_state  <= '0;
      overrun     <= 1'b0;
    end else begin
      if (enable) begin
        wcnt     <= win_end ? '0 : wcnt + 1'b1;
        gap      <= spike ? '0 : gap_inc;
        last_isi <= last_isi_nxt;
        seen     <= seen | spike;
        // The snapshot takes this cycle's updates; accumulators restart for the next window.
        cnt      <= win_end ? '0 : cnt_nxt;
        pk       <= win_end ? '0 : pk_nxt;
      end
      if (load) begin
        out_valid   <= 1'b1;
        spike_count <= cnt_nxt;
        isi         <= last_isi_nxt;
        peak_state  <= pk_nxt;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (win_end && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor: two instances (16/8/8 and 32/4/3) with
// expected records queued at stimulus time and checked by monitors on each transfer.
module tb_lif_spike_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WINDOW_LEN=16, COUNT_W=8, ISI_W=8
  logic       a_reset, a_en, a_spike, a_ready;
  logic [7:0] a_state;
  logic       a_valid, a_overrun;
  logic [7:0] a_count, a_isi, a_peak;
  logic [23:0] a_rec;
  assign a_rec = {a_count, a_isi, a_peak};

  // Instance B: WINDOW_LEN=32, COUNT_W=4, ISI_W=3
  logic       b_reset, b_en, b_spike, b_ready;
  logic [7:0] b_state;
  logic       b_valid, b_overrun;
  logic [3:0] b_count;
  logic [2:0] b_isi;
  logic [7:0] b_peak;
  logic [23:0] b_rec;
  assign b_rec = {4'h0, b_count, 5'h0, b_isi, b_peak};

  lif_spike_monitor #(.WINDOW_LEN(16), .COUNT_W(8), .ISI_W(8)) u_a (
    .clk(clk), .reset(a_reset), .enable(a_en), .spike(a_spike), .state(a_state),
    .out_ready(a_ready), .out_valid(a_valid), .spike_count(a_count), .isi(a_isi),
    .peak_state(a_peak), .overrun(a_overrun)
  );

  lif_spike_monitor #(.WINDOW_LEN(32), .COUNT_W(4), .ISI_W(3)) u_b (
    .clk(clk), .reset(b_reset), .enable(b_en), .spike(b_spike), .state(b_state),
    .out_ready(b_ready), .out_valid(b_valid), .spike_count(b_count), .isi(b_isi),
    .peak_state(b_peak), .overrun(b_overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_a_q[$];
  logic [23:0] exp_b_q[$];
  logic [23:0] exp_a_v, exp_b_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitors: compare on every transfer edge
  always @(negedge clk) begin
    if (a_reset === 1'b0 && a_valid === 1'b1 && a_ready === 1'b1) begin
      if (exp_a_q.size() == 0) check("a_unexpected_record", {8'h0, a_rec}, 32'hFFFF_FFFF);
      else begin
        exp_a_v = exp_a_q.pop_front();
        check("a_record", {8'h0, a_rec}, {8'h0, exp_a_v});
      end
    end
  end

  always @(negedge clk) begin
    if (b_reset === 1'b0 && b_valid === 1'b1 && b_ready === 1'b1) begin
      if (exp_b_q.size() == 0) check("b_unexpected_record", {8'h0, b_rec}, 32'hFFFF_FFFF);
      else begin
        exp_b_v = exp_b_q.pop_front();
        check("b_record", {8'h0, b_rec}, {8'h0, exp_b_v});
      end
    end
  end

  // Driver tasks: apply inputs, let one edge pass, return 1 time unit after it
  task automatic a_step(input logic r, input logic en, input logic sp,
                        input logic [7:0] st, input logic rdy);
    a_reset = r; a_en = en; a_spike = sp; a_state = st; a_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic b_step(input logic r, input logic en, input logic sp,
                        input logic [7:0] st, input logic rdy);
    b_reset = r; b_en = en; b_spike = sp; b_state = st; b_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic a_window(input logic [15:0] mask, input int mul, input int add,
                          input logic rdy_body, input logic rdy_end);
    for (int i = 0; i < 16; i++)
      a_step(1'b0, 1'b1, mask[i], 8'(i * mul + add), (i == 15) ? rdy_end : rdy_body);
  endtask

  initial begin
    b_reset = 1'b1; b_en = 1'b0; b_spike = 1'b0; b_state = 8'h0; b_ready = 1'b0;

    // ---------------- Instance A ----------------
    for (int i = 0; i < 2; i++)
      a_step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    check("a_reset_valid", a_valid, 0);
    check("a_reset_count", a_count, 0);
    check("a_reset_isi", a_isi, 0);
    check("a_reset_peak", a_peak, 0);
    check("a_reset_overrun", a_overrun, 0);

    exp_a_q.push_back({8'd0, 8'd0, 8'd0});
    for (int i = 0; i < 15; i++) a_step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("a_valid_before_first_end", a_valid, 0);
    a_step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("a_valid_16_after_release", a_valid, 1);
    a_step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("a_valid_clear_disabled_accept", a_valid, 0);

    // Periodic train, two windows, consumer always ready
    exp_a_q.push_back({8'd4, 8'd4, 8'd15});
    exp_a_q.push_back({8'd4, 8'd4, 8'd15});
    a_window(16'h8888, 1, 0, 1'b1, 1'b1);
    a_window(16'h8888, 1, 0, 1'b1, 1'b1);
    check("a_periodic_isi_across_boundary", a_isi, 4);
    a_step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Backpressure across two window ends
    exp_a_q.push_back({8'd1, 8'd1, 8'd20});
    a_window(16'h0001, 0, 20, 1'b0, 1'b0);
    check("a_bp_valid_first", a_valid, 1);
    check("a_bp_overrun_first", a_overrun, 0);
    a_window(16'h0014, 0, 99, 1'b0, 1'b0);
    check("a_bp_held_count", a_count, 1);
    check("a_bp_held_isi", a_isi, 1);
    check("a_bp_held_peak", a_peak, 20);
    check("a_bp_overrun_second", a_overrun, 1);
    a_step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("a_bp_valid_dropped", a_valid, 0);
    check("a_bp_overrun_sticky", a_overrun, 1);

    // Mid-window reset at wcnt=8
    for (int i = 0; i < 8; i++) a_step(1'b0, 1'b1, 1'b1, 8'd50, 1'b0);
    check("a_overrun_before_reset", a_overrun, 1);
    a_step(1'b1, 1'b1, 1'b1, 8'd50, 1'b0);
    check("a_overrun_after_reset", a_overrun, 0);
    check("a_valid_after_reset", a_valid, 0);
    check("a_count_after_reset", a_count, 0);

    exp_a_q.push_back({8'd2, 8'd1, 8'd30});
    for (int i = 0; i < 15; i++) a_step(1'b0, 1'b1, (i == 5 || i == 6), 8'(i * 2), 1'b0);
    check("a_fresh_window_not_early", a_valid, 0);
    a_step(1'b0, 1'b1, 1'b0, 8'd30, 1'b0);
    check("a_fresh_window_valid", a_valid, 1);

    // Accept on the window-end cycle while a record is held
    exp_a_q.push_back({8'd0, 8'd1, 8'd8});
    a_window(16'h0000, 0, 8, 1'b0, 1'b1);
    check("a_simul_valid", a_valid, 1);
    check("a_simul_overrun", a_overrun, 0);
    check("a_simul_peak", a_peak, 8);
    a_step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("a_simul_drain", a_valid, 0);

    // Enable gating: 5 disabled cycles with spike=1 mid-window
    exp_a_q.push_back({8'd1, 8'd28, 8'd15});
    for (int i = 0; i < 8; i++) a_step(1'b0, 1'b1, (i == 2), 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) a_step(1'b0, 1'b0, 1'b1, 8'd255, 1'b0);
    for (int i = 8; i < 11; i++) a_step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
    check("a_gate_no_end_at_16", a_valid, 0);
    for (int i = 11; i < 15; i++) a_step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
    check("a_gate_no_end_at_20", a_valid, 0);
    a_step(1'b0, 1'b1, 1'b0, 8'd15, 1'b0);
    check("a_gate_end_at_21", a_valid, 1);
    a_step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // ---------------- Instance B: saturation ----------------
    for (int i = 0; i < 2; i++)
      b_step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    check("b_reset_valid", b_valid, 0);
    exp_b_q.push_back({4'h0, 4'd15, 5'h0, 3'd1, 8'd31});
    exp_b_q.push_back({4'h0, 4'd0, 5'h0, 3'd1, 8'd0});
    exp_b_q.push_back({4'h0, 4'd1, 5'h0, 3'd7, 8'd0});
    for (int i = 0; i < 32; i++) b_step(1'b0, 1'b1, 1'b1, 8'(i), 1'b1);
    check("b_sat_count", b_count, 15);
    for (int i = 0; i < 32; i++) b_step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    check("b_quiet_isi", b_isi, 1);
    for (int i = 0; i < 32; i++) b_step(1'b0, 1'b1, (i == 0), 8'd0, 1'b1);
    check("b_gap_sat_isi", b_isi, 7);
    check("b_overrun", b_overrun, 0);
    b_step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    check("a_queue_empty", exp_a_q.size(), 0);
    check("b_queue_empty", exp_b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
